// File: rtl/fpmult_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fpmult_rr_scheduler
// Purpose  : Round-robin scheduler sharing one pipelined single-precision FP
//            multiplier among NREQ requesters. The winner's operands are
//            routed to the multiplier, and its ID travels down a tag pipeline
//            matched to the multiplier latency. The product is returned to
//            that requester through a registered output stage.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1       clock, all state on rising edge
//   rst        in   1       asynchronous active-high reset
//   req_valid  in   NREQ    per-requester operand valid
//   req_ready  out  NREQ    one-hot grant (zero when idle or in reset)
//   req_x      in   NREQ*N  packed X operands, requester i at [i*N +: N]
//   req_y      in   NREQ*N  packed Y operands, same packing
//   mul_x      out  N       X operand to multiplier
//   mul_y      out  N       Y operand to multiplier
//   mul_m      in   N       multiplier product, valid LAT cycles after issue
//   res_valid  out  NREQ    one-hot result strobe (single-cycle pulse)
//   res_data   out  N       result word, broadcast
//   res_id     out  IDW     owner of res_data
//   busy       out  1       any tag stage or the output stage is valid
// ----------------------------------------------------------------------------
// Build option
//   FPMULT_SCHED_ZERO_BYPASS_EN : when defined, an operand with a zero
//   exponent field forces a signed-zero result, because the multiplier
//   datapath does not handle zero or denormal inputs.
// ============================================================================
module fpmult_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int N    = 32,
  parameter int LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_x,
  input  logic [NREQ*N-1:0] req_y,
  output logic [N-1:0]      mul_x,
  output logic [N-1:0]      mul_y,
  input  logic [N-1:0]      mul_m,
  output logic [NREQ-1:0]   res_valid,
  output logic [N-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);

  localparam int              c_EXP_W = 8;
  localparam int              c_LAST  = LAT - 1;
  localparam logic [NREQ-1:0] c_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

  logic [IDW-1:0]  r_ptr;
  logic            w_found;
  logic [IDW-1:0]  w_winner;
  logic            w_issue;
  logic [IDW-1:0]  w_ptr_next;
  logic [N-1:0]    w_win_x;
  logic [N-1:0]    w_win_y;

  logic            r_tag_vld [LAT];
  logic [IDW-1:0]  r_tag_id  [LAT];
  logic            w_tag_any;

  logic [NREQ-1:0] r_res_valid;
  logic [N-1:0]    r_res_data;
  logic [IDW-1:0]  r_res_id;
  logic [N-1:0]    w_res_word;

  // --------------------------------------------------------------------------
  // Arbitration: scan from r_ptr upward (mod NREQ). The loop runs from the
  // farthest offset down to r_ptr so the nearest asserted request is the
  // last one written and therefore wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_found  = 1'b1;
        w_winner = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // Grant is suppressed while reset is held so nothing issues into a
  // pipeline that is being cleared.
  assign w_issue   = w_found & ~rst;
  assign req_ready = w_issue ? (c_ONE << w_winner) : '0;

  assign w_win_x = req_x[int'(w_winner)*N +: N];
  assign w_win_y = req_y[int'(w_winner)*N +: N];
  assign mul_x   = w_issue ? w_win_x : '0;
  assign mul_y   = w_issue ? w_win_y : '0;

  assign w_ptr_next = (w_winner == IDW'(NREQ - 1)) ? '0 : (w_winner + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= w_ptr_next;
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipeline: shifts every cycle, there is no stall path.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_id[s]  <= '0;
      end
    end else begin
      for (int s = LAT - 1; s > 0; s--) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
      r_tag_vld[0] <= w_issue;
      r_tag_id[0]  <= w_winner;
    end
  end

`ifdef FPMULT_SCHED_ZERO_BYPASS_EN
  logic w_zflag;
  logic w_zsign;
  logic r_tag_z [LAT];
  logic r_tag_s [LAT];

  assign w_zflag = (w_win_x[N-2 -: c_EXP_W] == '0) | (w_win_y[N-2 -: c_EXP_W] == '0);
  assign w_zsign = w_win_x[N-1] ^ w_win_y[N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        r_tag_z[s] <= 1'b0;
        r_tag_s[s] <= 1'b0;
      end
    end else begin
      for (int s = LAT - 1; s > 0; s--) begin
        r_tag_z[s] <= r_tag_z[s-1];
        r_tag_s[s] <= r_tag_s[s-1];
      end
      r_tag_z[0] <= w_issue & w_zflag;
      r_tag_s[0] <= w_zsign;
    end
  end

  // A zero/denormal operand yields a correctly signed zero instead of the
  // multiplier's meaningless output.
  assign w_res_word = r_tag_z[c_LAST] ? {r_tag_s[c_LAST], {(N-1){1'b0}}} : mul_m;
`else
  assign w_res_word = mul_m;
`endif

  // --------------------------------------------------------------------------
  // Output stage: captures the product as the last tag stage leaves. Data
  // and ID hold their last value between pulses.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= '0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      r_res_valid <= r_tag_vld[c_LAST] ? (c_ONE << r_tag_id[c_LAST]) : '0;
      if (r_tag_vld[c_LAST]) begin
        r_res_data <= w_res_word;
        r_res_id   <= r_tag_id[c_LAST];
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

  always_comb begin
    w_tag_any = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      w_tag_any = w_tag_any | r_tag_vld[s];
    end
  end

  assign busy = w_tag_any | (|r_res_valid);

endmodule
`default_nettype wire

// File: tb/tb_fpmult_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpmult_rr_scheduler
// Purpose  : Scoreboard bench for fpmult_rr_scheduler. The driver checks each
//            grant against a round-robin reference and queues the expected
//            result; a monitor pops and compares whenever res_valid pulses.
//            A small truncating FP multiplier model plays the datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpmult_rr_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int N    = 32;
  localparam int LAT  = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_x;
  logic [NREQ*N-1:0] req_y;
  logic [N-1:0]      mul_x;
  logic [N-1:0]      mul_y;
  logic [N-1:0]      mul_m;
  logic [NREQ-1:0]   res_valid;
  logic [N-1:0]      res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;

  fpmult_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_m(mul_m),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Truncating multiplier for normal numbers; the hidden bit is always
  // assumed, so zero/denormal inputs give a wrong (but predictable) result.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] expect_word(input logic [31:0] a, input logic [31:0] b);
`ifdef FPMULT_SCHED_ZERO_BYPASS_EN
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
`endif
    return fmul(a, b);
  endfunction

  logic [N-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_x, mul_y);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_m = mpipe[LAT-1];

  typedef struct {
    int          id;
    logic [31:0] data;
    int          iss;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          m_ptr = 0;
  logic [31:0] hand [NREQ];
  bit          hand_set [NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y);
    req_x[i*N +: N] = x;
    req_y[i*N +: N] = y;
  endtask

  task automatic set_hand(input int i, input logic [31:0] v);
    hand[i]     = v;
    hand_set[i] = 1'b1;
  endtask

  // One bus cycle: check grant and operand routing, queue the expectation.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    logic [31:0]     xw, yw;
    exp_t            e;
    int              w;
    bit              found;
    @(negedge clk);
    found = 0;
    w     = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(m_ptr + k) % NREQ]) begin
        found = 1;
        w     = (m_ptr + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (found) exp_rdy[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (found) begin
      xw = req_x[w*N +: N];
      yw = req_y[w*N +: N];
      check("mul_x", 64'(mul_x), 64'(xw));
      check("mul_y", 64'(mul_y), 64'(yw));
      e.id   = w;
      e.data = hand_set[w] ? hand[w] : expect_word(xw, yw);
      e.iss  = cyc;
      hand_set[w] = 1'b0;
      sbq.push_back(e);
      m_ptr = (w + 1) % NREQ;
    end else begin
      check("mul_x_idle", 64'(mul_x), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) step();
  endtask

  // Reset raised mid-cycle: everything clears immediately, the queue of
  // in-flight work is dropped and the reference pointer restarts at 0.
  task automatic reset_mid();
    rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    sbq.delete();
    m_ptr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: busy reference and result scoreboard.
  exp_t mon_e;
  bit   mon_busy;
  logic [NREQ-1:0] mon_oh;
  always @(negedge clk) begin
    if (!rst) begin
      mon_busy = 0;
      foreach (sbq[i]) if (sbq[i].iss < cyc) mon_busy = 1;
      check("busy", 64'(busy), 64'(mon_busy));
      if (res_valid != '0) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got res_valid %b, expected none (cycle %0d)", res_valid, cyc);
        end else begin
          mon_e  = sbq.pop_front();
          mon_oh = '0;
          mon_oh[mon_e.id] = 1'b1;
          check("res_valid", 64'(res_valid), 64'(mon_oh));
          check("res_id", 64'(res_id), 64'(mon_e.id));
          check("res_data", 64'(res_data), 64'(mon_e.data));
          check("latency", 64'(cyc), 64'(mon_e.iss + LAT + 1));
        end
      end else if (sbq.size() > 0 && sbq[0].iss + LAT + 1 <= cyc) begin
        mon_e = sbq.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL missing_result: got none, expected id %0d (cycle %0d)", mon_e.id, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0001;
    req_x     = '0;
    req_y     = '0;
    for (int i = 0; i < NREQ; i++) hand_set[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_res_data", 64'(res_data), 64'd0);
    req_valid = '0;
    rst       = 1'b0;

    // 1.5 * 2.0 from requester 2.
    set_op(2, 32'h3FC00000, 32'h40000000);
    set_hand(2, 32'h40400000);
    req_valid = 4'b0100;
    step();
    idle(4);

    // Zero-exponent operands (requester 3 then 0).
    set_op(3, 32'h80000000, 32'h40000000);
`ifdef FPMULT_SCHED_ZERO_BYPASS_EN
    set_hand(3, 32'h80000000);
`else
    set_hand(3, 32'h80800000);
`endif
    req_valid = 4'b1000;
    step();
    set_op(0, 32'h00000000, 32'h40400000);
`ifdef FPMULT_SCHED_ZERO_BYPASS_EN
    set_hand(0, 32'h00000000);
`else
    set_hand(0, 32'h00C00000);
`endif
    req_valid = 4'b0001;
    step();
    idle(3);

    // ptr=1: requester 1 wins, requester 0 withdraws without issuing.
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(1, 32'h40000000, 32'h40400000);
    req_valid = 4'b0011;
    step();
    req_valid = 4'b0000;
    step();
    set_op(2, 32'h40800000, 32'h3F000000);
    req_valid = 4'b0101;
    step();
    idle(3);

    // Move ptr to 2, then requesters 1 and 3 contend: 3, 1, 3.
    set_op(1, 32'h3FA00000, 32'h3FA00000);
    req_valid = 4'b0010;
    step();
    set_op(3, 32'h40A00000, 32'h40C00000);
    req_valid = 4'b1010;
    repeat (3) step();
    idle(3);

    // All four valid for 8 cycles from ptr=0.
    for (int i = 0; i < NREQ; i++)
      set_op(i, 32'h3F800000 | (32'(i) << 20), 32'h40000000 | (32'(i) << 19));
    req_valid = 4'b1111;
    repeat (8) step();
    idle(3);

    // Reset with operations in flight, then lowest requester from 0 wins.
    req_valid = 4'b1111;
    repeat (3) step();
    reset_mid();
    req_valid = 4'b1010;
    step();
    idle(6);

    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
